// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with write-through bypass on both decode read ports,
// a registered debug read port and a committed-write counter.
module wb_regfile #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int CNT_W  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic [ADDR_W-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [ADDR_W-1:0] Rs1D,
    input  logic [ADDR_W-1:0] Rs2D,
    output logic [XLEN-1:0]   RD1D,
    output logic [XLEN-1:0]   RD2D,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [XLEN-1:0]   DbgData,
    output logic [CNT_W-1:0]  WbCount
);
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [XLEN-1:0]  r_dbg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_we;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;
    logic [XLEN-1:0]  w_dbg;

    // x0 and out-of-range addresses read as zero; otherwise a same-cycle write wins over the array.
    function automatic logic [XLEN-1:0] rd_sel(input logic [ADDR_W-1:0] a, input logic we,
                                               input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] res,
                                               input logic [XLEN-1:0] q);
        return (a == '0 || int'(a) >= NREGS) ? '0 : (we && rd == a) ? res : q;
    endfunction

    always_comb begin
        w_we  = RegWriteW && RdW != '0 && int'(RdW) < NREGS;
        w_rd1 = rd_sel(Rs1D, RegWriteW, RdW, ResultW, r_regs[Rs1D]);
        w_rd2 = rd_sel(Rs2D, RegWriteW, RdW, ResultW, r_regs[Rs2D]);
        w_dbg = rd_sel(DbgAddr, RegWriteW, RdW, ResultW, r_regs[DbgAddr]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_dbg <= '0;
            r_cnt <= '0;
        end else begin
            if (w_we) begin
                r_regs[RdW] <= ResultW;
                r_cnt       <= r_cnt + 1'b1;
            end
            r_dbg <= w_dbg;
        end
    end

    assign RD1D    = w_rd1;
    assign RD2D    = w_rd2;
    assign DbgData = r_dbg;
    assign WbCount = r_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: random and directed checks of wb_regfile against an array model; a second
// instance (24 registers, 4-bit counter) covers out-of-range addresses and counter wrap.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  RdW, Rs1D, Rs2D, DbgAddr;
    logic [31:0] ResultW, RD1D, RD2D, DbgData, WbCount;
    logic [31:0] s_rd1, s_rd2, s_dbg;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
        .DbgAddr(DbgAddr), .DbgData(DbgData), .WbCount(WbCount)
    );

    wb_regfile #(.NREGS(24), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(s_rd1), .RD2D(s_rd2),
        .DbgAddr(DbgAddr), .DbgData(s_dbg), .WbCount(s_cnt)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m  [32];
    logic [31:0] ms [32];
    logic [31:0] cnt;
    logic [3:0]  cnts;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input int n, input logic [4:0] a, input logic [31:0] v);
        if (a == 0 || int'(a) >= n) return 32'h0;
        if (RegWriteW && RdW == a) return ResultW;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m[i]  = 0;
            ms[i] = 0;
        end
        cnt  = 0;
        cnts = 0;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
        @(negedge clk);
        RegWriteW = we; RdW = rd; ResultW = res; Rs1D = a1; Rs2D = a2; DbgAddr = dbg;
    endtask

    task automatic step(input string tag);
        logic [31:0] ed, eds;
        #1;
        chk({tag, ".rd1"}, RD1D, mrd(32, Rs1D, m[Rs1D]));
        chk({tag, ".rd2"}, RD2D, mrd(32, Rs2D, m[Rs2D]));
        chk({tag, ".s_rd1"}, s_rd1, mrd(24, Rs1D, ms[Rs1D]));
        chk({tag, ".s_rd2"}, s_rd2, mrd(24, Rs2D, ms[Rs2D]));
        ed  = mrd(32, DbgAddr, m[DbgAddr]);
        eds = mrd(24, DbgAddr, ms[DbgAddr]);
        @(posedge clk);
        if (RegWriteW && RdW != 0) begin
            m[RdW] = ResultW;
            cnt++;
        end
        if (RegWriteW && RdW != 0 && RdW < 24) begin
            ms[RdW] = ResultW;
            cnts++;
        end
        #1;
        chk({tag, ".dbg"}, DbgData, ed);
        chk({tag, ".s_dbg"}, s_dbg, eds);
        chk({tag, ".cnt"}, WbCount, cnt);
        chk({tag, ".s_cnt"}, {28'h0, s_cnt}, {28'h0, cnts});
    endtask

    initial begin
        reset = 1'b1;
        RegWriteW = 0; RdW = 0; ResultW = 0; Rs1D = 0; Rs2D = 0; DbgAddr = 0;
        model_clear();
        @(negedge clk);
        chk("rst.cnt", WbCount, 32'h0);
        chk("rst.dbg", DbgData, 32'h0);
        chk("rst.rd1", RD1D, 32'h0);
        reset = 1'b0;

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0); step("t2w");
        drive(0, 0, 0, 5, 0, 0);
        #1 chk("t2.rd1", RD1D, 32'hDEADBEEF);
        chk("t2.cnt", WbCount, 32'd1);
        step("t2r");

        drive(1, 7, 32'd1, 0, 0, 0); step("t3w");
        drive(1, 7, 32'd2, 7, 7, 7);
        #1 chk("t3.rd1", RD1D, 32'd2);
        chk("t3.rd2", RD2D, 32'd2);
        step("t3b");
        drive(0, 0, 0, 7, 0, 0);
        #1 chk("t3.after", RD1D, 32'd2);
        step("t3r");

        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        #1 chk("t4.same", RD1D, 32'h0);
        step("t4w");
        chk("t4.cnt", WbCount, 32'd3);
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("t4.next", RD1D, 32'h0);
        step("t4r");

        drive(1, 3, 32'h1234, 0, 0, 0); step("t5w");
        drive(0, 0, 0, 0, 0, 3); step("t5d");
        chk("t5.dbg", DbgData, 32'h1234);
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, i, 0, 0, 0); step("t5c");
        end
        chk("t5.wrap", {28'h0, s_cnt}, 32'h0);
        chk("t5.cnt16", WbCount, 32'd16);

        drive(1, 25, 32'hAAAA5555, 25, 25, 25);
        #1 chk("oor.byp", s_rd1, 32'h0);
        step("oor");

        for (int k = 0; k < 10000; k++) begin
            logic [4:0] rd, a1;
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, rd, $urandom, a1, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
            step("rnd");
        end

        for (int i = 1; i < 32; i++) begin
            drive(1, 5'(i), 32'h100 + i, 0, 0, 0); step("fill");
        end
        drive(0, 0, 0, 1, 31, 5); step("pre");
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t1.rd1", RD1D, 32'h0);
        chk("t1.rd2", RD2D, 32'h0);
        chk("t1.cnt", WbCount, 32'h0);
        chk("t1.dbg", DbgData, 32'h0);
        chk("t1.s_cnt", {28'h0, s_cnt}, 32'h0);
        RegWriteW = 1; RdW = 9; ResultW = 32'h99; Rs1D = 1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        RegWriteW = 0; Rs1D = 9;
        model_clear();
        #1 chk("t1.discard", RD1D, 32'h0);
        chk("t1.cnt2", WbCount, 32'h0);
        step("post");
        drive(1, 9, 32'h77, 9, 0, 9); step("post2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
